// File: rtl/spike_synapse_if.sv
// Spike synapse port bundle: presynaptic spike/weight/enable in,
// integrated synaptic current and event status out.
interface spike_synapse_if;
  logic               spike_in;
  logic signed [15:0] weight;
  logic               enable;
  logic signed [15:0] current;
  logic               event_out;
  logic [7:0]         spike_count;

  modport master (
    output spike_in, weight, enable,
    input  current, event_out, spike_count
  );

  modport slave (
    input  spike_in, weight, enable,
    output current, event_out, spike_count
  );
endinterface

// File: rtl/spike_synapse.sv
// Spike synapse: rising-edge detect, fixed axonal delay line carrying the
// sampled weight, and a leaky saturating signed current integrator.
module spike_synapse #(
  parameter int                 DELAY       = 4,
  parameter int                 DECAY_SHIFT = 3,
  parameter logic signed [15:0] I_MAX       = 16'sd16383,
  parameter logic signed [15:0] I_MIN       = -16'sd16384
) (
  input logic            clk,
  input logic            reset,
  spike_synapse_if.slave sif
);

  logic               spike_prev_r;
  logic [DELAY-1:0]   valid_r;
  logic signed [15:0] weight_r [DELAY];
  logic signed [15:0] current_r;
  logic               event_r;
  logic [7:0]         count_r;

  logic               edge_s;
  logic signed [17:0] cur_ext_s;
  logic signed [17:0] dec_s;
  logic signed [17:0] add_s;
  logic signed [17:0] sum_s;
  logic signed [15:0] current_next_s;

  function automatic logic signed [15:0] clamp_current(input logic signed [17:0] v);
    logic signed [17:0] hi;
    logic signed [17:0] lo;
    hi = {{2{I_MAX[15]}}, I_MAX};
    lo = {{2{I_MIN[15]}}, I_MIN};
    if (v > hi) begin
      clamp_current = I_MAX;
    end else if (v < lo) begin
      clamp_current = I_MIN;
    end else begin
      clamp_current = v[15:0];
    end
  endfunction

  // Edge detect and next-current arithmetic at 18 bits.
  always_comb begin
    edge_s    = sif.spike_in & ~spike_prev_r;
    cur_ext_s = {{2{current_r[15]}}, current_r};
    dec_s     = cur_ext_s >>> DECAY_SHIFT;
    // A small positive residue would otherwise never leak away.
    if ((current_r > 16'sd0) && (dec_s == 18'sd0)) begin
      dec_s = 18'sd1;
    end else begin
      dec_s = dec_s;
    end
    if (valid_r[DELAY-1]) begin
      add_s = {{2{weight_r[DELAY-1][15]}}, weight_r[DELAY-1]};
    end else begin
      add_s = 18'sd0;
    end
    sum_s          = cur_ext_s - dec_s + add_s;
    current_next_s = clamp_current(sum_s);
  end

  // Delay line shift, current integration, event flag and delivery counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      spike_prev_r <= 1'b0;
      valid_r      <= '0;
      for (int i = 0; i < DELAY; i++) begin
        weight_r[i] <= 16'sd0;
      end
      current_r <= 16'sd0;
      event_r   <= 1'b0;
      count_r   <= 8'd0;
    end else begin
      spike_prev_r <= sif.spike_in;
      valid_r[0]   <= edge_s & sif.enable;
      weight_r[0]  <= sif.weight;
      for (int i = 1; i < DELAY; i++) begin
        valid_r[i]  <= valid_r[i-1];
        weight_r[i] <= weight_r[i-1];
      end
      current_r <= current_next_s;
      event_r   <= valid_r[DELAY-1];
      if (valid_r[DELAY-1] && (count_r != 8'd255)) begin
        count_r <= count_r + 8'd1;
      end else begin
        count_r <= count_r;
      end
    end
  end

  assign sif.current     = current_r;
  assign sif.event_out   = event_r;
  assign sif.spike_count = count_r;

endmodule

// File: tb/tb_spike_synapse.sv
// Self-checking bench for spike_synapse: directed vector table, counter
// saturation run, and randomized traffic against a delivery-schedule model.
module tb_spike_synapse;
  localparam int DELAY = 4;
  localparam int DECAY_SHIFT = 3;
  localparam int I_MAX = 16383;
  localparam int I_MIN = -16384;

  logic clk = 1'b0;
  logic reset;
  spike_synapse_if sif ();

  spike_synapse #(
    .DELAY(DELAY), .DECAY_SHIFT(DECAY_SHIFT),
    .I_MAX(16'sd16383), .I_MIN(-16'sd16384)
  ) dut (
    .clk(clk), .reset(reset), .sif(sif)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: deliveries scheduled by absolute cycle in a ring of future slots.
  int unsigned        t_now = 0;
  bit                 sched_v [32];
  logic signed [15:0] sched_w [32];
  int                 m_cur = 0;
  bit                 m_ev = 1'b0;
  int                 m_cnt = 0;
  bit                 m_prev = 1'b0;

  function automatic int floor_div(input int a, input int d);
    if (a >= 0) return a / d;
    return -((-a + d - 1) / d);
  endfunction

  function automatic void model_step(input bit s, input logic signed [15:0] w, input bit en, input bit r);
    int slot;
    int dec;
    int nxt;
    bit dv;
    slot = int'(t_now % 32);
    if (r) begin
      for (int i = 0; i < 32; i++) sched_v[i] = 1'b0;
      m_cur = 0; m_ev = 1'b0; m_cnt = 0; m_prev = 1'b0;
    end else begin
      dv = sched_v[slot];
      sched_v[slot] = 1'b0;
      dec = floor_div(m_cur, 1 << DECAY_SHIFT);
      if (m_cur > 0 && dec == 0) dec = 1;
      nxt = m_cur - dec + (dv ? int'(sched_w[slot]) : 0);
      if (nxt > I_MAX) nxt = I_MAX;
      if (nxt < I_MIN) nxt = I_MIN;
      m_cur = nxt;
      m_ev = dv;
      if (dv && m_cnt < 255) m_cnt++;
      if (s && !m_prev && en) begin
        sched_v[(t_now + DELAY) % 32] = 1'b1;
        sched_w[(t_now + DELAY) % 32] = w;
      end
      m_prev = s;
    end
    t_now++;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", name, t_now, act, exp);
    end
  endtask

  task automatic step(input bit s, input logic signed [15:0] w, input bit en, input bit r);
    sif.spike_in = s; sif.weight = w; sif.enable = en; reset = r;
    @(posedge clk);
    model_step(s, w, en, r);
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_current"}, int'(sif.current), m_cur);
    chk({tag, "_event"}, int'(sif.event_out), int'(m_ev));
    chk({tag, "_count"}, int'(sif.spike_count), m_cnt);
  endtask

  typedef struct {
    bit                 s;
    logic signed [15:0] w;
    bit                 en;
    bit                 r;
    int                 cur;
    bit                 ev;
    int                 cnt;
  } vec_t;
  vec_t tbl [$];

  function automatic void add(input bit s, input logic signed [15:0] w, input bit en,
                              input bit r, input int cur, input bit ev, input int cnt);
    vec_t v;
    v.s = s; v.w = w; v.en = en; v.r = r; v.cur = cur; v.ev = ev; v.cnt = cnt;
    tbl.push_back(v);
  endfunction

  // Two reset cycles with spike held high, then one edge at row 0; en_mode:
  // 0 = enable off, 1 = enable on, 2 = enable only on the edge cycle.
  function automatic void burst(input logic signed [15:0] w, input int en_mode, input int exps [9]);
    bit on;
    on = (en_mode != 0);
    add(1'b1, w, 1'b1, 1'b1, 0, 1'b0, 0);
    add(1'b1, w, 1'b1, 1'b1, 0, 1'b0, 0);
    for (int j = 0; j < 9; j++) begin
      add(j == 0, w, (en_mode == 1) || (en_mode == 2 && j == 0), 1'b0,
          on ? exps[j] : 0, on && (j == 4), (on && j >= 4) ? 1 : 0);
    end
  endfunction

  function automatic void sat_seq(input logic signed [15:0] w, input int e4, input int e5,
                                  input int e6, input int e7);
    int pat [8] = '{1, 0, 1, 0, 0, 0, 0, 0};
    int ex  [8];
    ex = '{0, 0, 0, 0, e4, e5, e6, e7};
    add(1'b0, w, 1'b1, 1'b1, 0, 1'b0, 0);
    for (int j = 0; j < 8; j++) begin
      add(pat[j] == 1, w, 1'b1, 1'b0, ex[j], (j == 4 || j == 6),
          (j >= 6) ? 2 : ((j >= 4) ? 1 : 0));
    end
  endfunction

  function automatic void build_table();
    int held [12] = '{0, 0, 0, 0, 5, 4, 3, 2, 1, 0, 0, 0};
    burst(16'sd1000, 1, '{0, 0, 0, 0, 1000, 875, 766, 671, 588});
    burst(-16'sd800, 1, '{0, 0, 0, 0, -800, -700, -612, -535, -468});
    burst(-16'sd3,   1, '{0, 0, 0, 0, -3, -2, -1, 0, 0});
    burst(16'sd1000, 0, '{0, 0, 0, 0, 0, 0, 0, 0, 0});
    burst(16'sd500,  2, '{0, 0, 0, 0, 500, 438, 384, 336, 294});
    add(1'b0, 16'sd5, 1'b1, 1'b1, 0, 1'b0, 0);
    for (int j = 0; j < 12; j++) begin
      add(j < 10, 16'sd5, 1'b1, 1'b0, held[j], j == 4, (j >= 4) ? 1 : 0);
    end
    sat_seq(16'sd16000, 16000, 14000, 16383, 14336);
    sat_seq(-16'sd16000, -16000, -14000, -16384, -14336);
    add(1'b0, 16'sd1000, 1'b1, 1'b1, 0, 1'b0, 0);
    add(1'b1, 16'sd1000, 1'b1, 1'b0, 0, 1'b0, 0);
    add(1'b0, 16'sd1000, 1'b1, 1'b0, 0, 1'b0, 0);
    add(1'b0, 16'sd1000, 1'b1, 1'b1, 0, 1'b0, 0);
    for (int j = 0; j < 6; j++) add(1'b0, 16'sd1000, 1'b1, 1'b0, 0, 1'b0, 0);
  endfunction

  initial begin
    logic signed [15:0] rw;
    sif.spike_in = 1'b0; sif.weight = 16'sd0; sif.enable = 1'b0; reset = 1'b1;
    for (int i = 0; i < 32; i++) begin
      sched_v[i] = 1'b0;
      sched_w[i] = 16'sd0;
    end
    build_table();

    foreach (tbl[i]) begin
      step(tbl[i].s, tbl[i].w, tbl[i].en, tbl[i].r);
      chk($sformatf("vec%0d_current", i), int'(sif.current), tbl[i].cur);
      chk($sformatf("vec%0d_event", i), int'(sif.event_out), int'(tbl[i].ev));
      chk($sformatf("vec%0d_count", i), int'(sif.spike_count), tbl[i].cnt);
    end

    step(1'b0, 16'sd0, 1'b1, 1'b1);
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 16'sd0, 1'b1, 1'b0);
      chk("cnt_run_current_zero", int'(sif.current), 0);
      step(1'b0, 16'sd0, 1'b1, 1'b0);
      chk_model("cnt_run");
    end
    for (int i = 0; i < DELAY + 2; i++) step(1'b0, 16'sd0, 1'b1, 1'b0);
    chk("count_saturated", int'(sif.spike_count), 255);
    chk("count_sat_current", int'(sif.current), 0);

    step(1'b0, 16'sd0, 1'b1, 1'b1);
    chk_model("rand_reset");
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 1) == 0) rw = 16'($urandom);
      else rw = 16'($signed($urandom_range(0, 4000)) - 2000);
      step($urandom_range(0, 99) < 40, rw, $urandom_range(0, 3) != 0,
           $urandom_range(0, 199) == 0);
      chk_model("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
